pad_ctrl_arbiter: RTL
=====================

Name: pad_ctrl_arbiter

Overview:
Shares one bank of bidirectional pad controls (output value, output enable, pull-up, pull-down) among several DV/test requesters, such as multiple agents that need the same GPIO/strap pins. A round-robin arbiter grants exclusive ownership. Every ownership change is bracketed by turnaround windows in which no requester drives, so two drivers never overlap on the pins. Outputs connect directly to a pin interface's drive, output-enable and pull controls.

Parameters:
NumReq, 4, number of requesters (>=2)
Width, 8, number of pins in the bank
TurnCycles, 2, idle cycles with oe=0 before a grant and after a release (0..15; 0 skips the window)
IdlePuMask, '0, Width-bit pull-up pattern applied while no owner
IdlePdMask, '0, Width-bit pull-down pattern applied while no owner
MaxHold, 64, hold-cycle limit (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NumReq  per-requester ownership request; held high for the whole tenure
req_out_i  in  NumReq*Width  per-requester pin output values, requester k at [k*Width +: Width]
req_oe_i  in  NumReq*Width  per-requester output enables
req_pu_i  in  NumReq*Width  per-requester pull-up enables
req_pd_i  in  NumReq*Width  per-requester pull-down enables
gnt_o  out  NumReq  one-hot grant, registered
owner_o  out  $clog2(NumReq)  index of current or pending owner
busy_o  out  1  high in any state other than IDLE
pins_o  out  Width  value to drive
pins_oe_o  out  Width  output enable
pins_pu_o  out  Width  pull-up enable
pins_pd_o  out  Width  pull-down enable
timeout_o  out  1  one-cycle pulse on forced release (optional feature only)

Behaviour:
- Reset (async assert, sync deassert internally): state=IDLE, gnt_o=0, owner_o=0, rr pointer=0, busy_o=0, pins_o=0, pins_oe_o=0, pins_pu_o=IdlePuMask, pins_pd_o=IdlePdMask, timeout_o=0.
- Reset mid-tenure: all outputs take reset values immediately; no turnaround is applied.
- FSM states: IDLE, TURN, OWN, DRAIN.
- IDLE: if any req_i bit is high, select the first set bit at or after the rr pointer (wrapping), register it into owner_o, and go to TURN with counter=TurnCycles. If TurnCycles=0, go straight to OWN.
- TURN: counter decrements each cycle. At 0 go to OWN and assert gnt_o[owner] in the same registered update. If req_i[owner] drops during TURN, return to IDLE with no grant; rr pointer is unchanged.
- Grant latency: req_i rising at cycle 0 from IDLE gives gnt_o high at cycle 1+TurnCycles.
- OWN: pins_o/oe/pu/pd are a combinational mux of the owner's slices. Requests from other requesters are ignored (no preemption). When req_i[owner] falls, gnt_o drops next cycle, rr pointer becomes owner+1 mod NumReq, and the FSM enters DRAIN with counter=TurnCycles (IDLE if TurnCycles=0).
- DRAIN: counter decrements each cycle; at 0 go to IDLE. New requests wait.
- In every state except OWN: pins_oe_o=0, pins_o=0, pins_pu_o=IdlePuMask, pins_pd_o=IdlePdMask.
- pu and pd are passed through unchanged. Resolving pull-up/pull-down priority is the pin interface's job.
- Simultaneous requests: round-robin order only. A requester that just released has the lowest priority on the next arbitration.
- Minimum gap between owner A's last OWN cycle and owner B's first OWN cycle: 2*TurnCycles+2 cycles.

Optional Feature:
PAD_ARB_TIMEOUT_EN
- Defined: a hold counter starts on entry to OWN. After MaxHold cycles in OWN the block forces a release, exactly as if req_i[owner] had fallen: gnt_o drops, timeout_o pulses for 1 cycle, the FSM enters DRAIN and the rr pointer advances. The evicted requester must drop and re-raise req_i before it is eligible again.
- Undefined: no counter, timeout_o is tied to 0, and tenure is unbounded.

Test Plan:
- Reset: rst_ni low with req_i=4'b1111 -> gnt_o=0, pins_oe_o=0, pins_pu_o=IdlePuMask, busy_o=0.
- Single request: TurnCycles=2, req_i[2] rises at cycle 0 -> gnt_o=4'b0100 at cycle 3. pins_oe_o=0 during cycles 0..2, then follows req_oe_i[2 slice], e.g. 8'hF0.
- Round-robin: req_i=4'b1011 held, each owner releases after 5 OWN cycles -> grant order 0,1,3,0. Each pins_oe_o=0 gap is >=6 cycles.
- Abort during turnaround: req_i[1] pulses for 2 cycles from IDLE -> no grant, state returns to IDLE, req_i[3] raised next is granted.
- Mid-tenure reset: owner 0 driving pins_o=8'hA5 with oe=8'hFF, rst_ni pulsed low -> pins_oe_o=0 within the reset cycle, gnt_o=0.
- PAD_ARB_TIMEOUT_EN with MaxHold=64: req_i[0] held -> gnt_o drops after 64 OWN cycles, 1-cycle timeout_o pulse, req_i[1] (pending) granted after the DRAIN+TURN windows.

Source files
------------

// File: rtl/pad_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pad_ctrl_arbiter
// Purpose  : Round-robin ownership arbiter for one shared bank of pad
//            controls (value, output enable, pull-up, pull-down). Each
//            ownership change is bracketed by turnaround windows with no
//            driver, so two requesters never drive the pins together.
// Option   : PAD_ARB_TIMEOUT_EN - bounds a tenure to MaxHold OWN cycles
//            and pulses timeout_o on a forced release.
// Revision : 1.0 - initial release
// ============================================================================
module pad_ctrl_arbiter #(
  parameter int              NumReq     = 4,
  parameter int              Width      = 8,
  parameter int              TurnCycles = 2,
  parameter logic [Width-1:0] IdlePuMask = '0,
  parameter logic [Width-1:0] IdlePdMask = '0,
  parameter int              MaxHold    = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq*Width-1:0]     req_out_i,
  input  logic [NumReq*Width-1:0]     req_oe_i,
  input  logic [NumReq*Width-1:0]     req_pu_i,
  input  logic [NumReq*Width-1:0]     req_pd_i,
  output logic [NumReq-1:0]           gnt_o,
  output logic [$clog2(NumReq)-1:0]   owner_o,
  output logic                        busy_o,
  output logic [Width-1:0]            pins_o,
  output logic [Width-1:0]            pins_oe_o,
  output logic [Width-1:0]            pins_pu_o,
  output logic [Width-1:0]            pins_pd_o,
  output logic                        timeout_o
);

  localparam int               c_OW       = $clog2(NumReq);
  localparam logic [c_OW-1:0]  c_LAST     = c_OW'(NumReq - 1);
  localparam logic [c_OW-1:0]  c_OW_ONE   = c_OW'(1);
  localparam logic [3:0]       c_TURN     = 4'(TurnCycles);
  localparam logic [NumReq-1:0] c_ONE     = NumReq'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TURN  = 2'd1,
    S_OWN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_OW-1:0]   r_owner, w_owner_nxt;
  logic [c_OW-1:0]   r_ptr,   w_ptr_nxt;
  logic [3:0]        r_cnt,   w_cnt_nxt;
  logic [NumReq-1:0] r_gnt,   w_gnt_nxt;
  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  logic [NumReq-1:0] w_elig;
  logic [c_OW-1:0]   w_pick;
  logic              w_any;
  logic              w_release;
  logic              w_own;
  int                w_idx;

  // Reset asserts asynchronously but is released in step with clk_i
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

`ifdef PAD_ARB_TIMEOUT_EN
  localparam int              c_HW        = $clog2(MaxHold + 1);
  localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(MaxHold - 1);
  localparam logic [c_HW-1:0] c_HOLD_ONE  = c_HW'(1);

  logic [c_HW-1:0]   r_hold;
  logic              r_timeout;
  logic [NumReq-1:0] r_block;
  logic              w_expire;
  logic              w_forced;

  // An evicted requester stays ineligible until it drops its request
  assign w_elig    = req_i & ~r_block;
  assign w_expire  = (r_state == S_OWN) && (r_hold == c_HOLD_LAST);
  assign w_forced  = w_expire && req_i[r_owner];
  assign w_release = (r_state == S_OWN) && (!req_i[r_owner] || w_expire);
  assign timeout_o = r_timeout;

  // Tenure length counter, timeout pulse and eviction mask
  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
      r_block   <= '0;
    end else begin
      r_hold    <= (r_state == S_OWN && !w_release) ? r_hold + c_HOLD_ONE : '0;
      r_timeout <= w_forced;
      r_block   <= (r_block & req_i) | (w_forced ? (c_ONE << r_owner) : '0);
    end
  end
`else
  logic w_unused_hold;

  assign w_elig        = req_i;
  assign w_release     = (r_state == S_OWN) && !req_i[r_owner];
  assign timeout_o     = 1'b0;
  assign w_unused_hold = (MaxHold > 0);
`endif

  // Round-robin pick: first eligible requester at or after the pointer
  always_comb begin
    w_pick = r_ptr;
    w_any  = 1'b0;
    w_idx  = 0;
    for (int i = 0; i < NumReq; i++) begin
      w_idx = (int'(r_ptr) + i) % NumReq;
      if (!w_any && w_elig[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx[c_OW-1:0];
      end
    end
  end

  // Next-state, owner, pointer, turnaround counter and grant
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_owner_nxt = w_pick;
          if (TurnCycles == 0) begin
            w_state_nxt = S_OWN;
            w_gnt_nxt   = c_ONE << w_pick;
          end else begin
            w_state_nxt = S_TURN;
            w_cnt_nxt   = c_TURN;
          end
        end
      end
      S_TURN: begin
        // Abandoned before the grant: the pointer keeps its position
        if (!req_i[r_owner]) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt <= 4'd1) begin
          w_state_nxt = S_OWN;
          w_gnt_nxt   = c_ONE << r_owner;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      S_OWN: begin
        if (w_release) begin
          w_gnt_nxt = '0;
          w_ptr_nxt = (r_owner == c_LAST) ? '0 : r_owner + c_OW_ONE;
          if (TurnCycles == 0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DRAIN;
            w_cnt_nxt   = c_TURN;
          end
        end
      end
      S_DRAIN: begin
        if (r_cnt <= 4'd1) w_state_nxt = S_IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Arbiter state register
  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  // Only the owner's slices reach the pins; all else is the idle pattern
  assign w_own     = (r_state == S_OWN);
  assign pins_o    = w_own ? req_out_i[r_owner*Width +: Width] : '0;
  assign pins_oe_o = w_own ? req_oe_i[r_owner*Width +: Width]  : '0;
  assign pins_pu_o = w_own ? req_pu_i[r_owner*Width +: Width]  : IdlePuMask;
  assign pins_pd_o = w_own ? req_pd_i[r_owner*Width +: Width]  : IdlePdMask;

  assign gnt_o   = r_gnt;
  assign owner_o = r_owner;
  assign busy_o  = (r_state != S_IDLE);

endmodule
`default_nettype wire
